// File: rtl/des_uart_pkg.sv
// Shared types and constants for the DES/UART byte-packing datapath.
//   block_t          64-bit cipher block
//   byte_t           one UART byte
//   BYTES_PER_BLOCK  bytes gathered per block
//   collect_state_t  receive-side collector states
package des_uart_pkg;

  typedef logic [63:0] block_t;
  typedef logic [7:0]  byte_t;

  localparam int unsigned BYTES_PER_BLOCK = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collect_state_t;

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer for the receive-side packer.
// Counts cycles while enabled; cleared by every received byte and held at 0
// when disabled. Raises a one-cycle terminal strobe when the count reaches
// TIMEOUT_CYCLES-1 without a byte arriving in that cycle.
// Ports:
//   clock    in  system clock, rising edge
//   reset    in  synchronous active-high reset
//   enable   in  collector is mid-block
//   clear    in  a byte arrived this cycle
//   expired  out terminal-count strobe (combinational)
module rx_gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] gap_cnt;

  // A byte in the terminal cycle wins: the strobe is suppressed by clear.
  assign expired = enable && !clear && (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear || !enable || expired) begin
      gap_cnt <= '0;
    end else begin
      gap_cnt <= gap_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_8to64.sv
// Receive-side byte packer: gathers 8 UART bytes into one 64-bit block and
// offers it to the DES pipeline over a valid/ready handshake. The first byte
// lands in data_out[63:56]. A new block can be collected while the previous
// one waits in the output register; a block completing while the register is
// still held (valid & !ready) is dropped and flagged with overrun.
// Optional inter-byte timeout: define FSM_8TO64_TIMEOUT_EN to discard a
// partial block after TIMEOUT_CYCLES idle cycles and pulse frame_err.
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   rx_data     in   received byte, valid while rx_done=1
//   rx_done     in   one-cycle strobe per received byte
//   data_out    out  assembled block, stable while held
//   data_valid  out  block available
//   data_ready  in   consumer accepts block
//   overrun     out  one-cycle pulse: completed block dropped
//   frame_err   out  one-cycle pulse: partial block discarded on timeout
module fsm_8to64
  import des_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_done,
  output logic [63:0]  data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         overrun,
  output logic         frame_err
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_BLOCK - 1);

  collect_state_t state;
  logic [2:0]     count;
  block_t         shreg;
  block_t         next_block;
  logic           block_done;
  logic           timeout;

  assign next_block = {shreg[55:0], rx_data};
  assign block_done = rx_done && (state == COLLECT) && (count == LAST_IDX);

`ifdef FSM_8TO64_TIMEOUT_EN
  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (state == COLLECT),
    .clear   (rx_done),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Collector: shift register, byte count, state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else if (rx_done) begin
      shreg <= next_block;
      case (state)
        IDLE: begin
          count <= 3'd1;
          state <= COLLECT;
        end
        COLLECT: begin
          if (count == LAST_IDX) begin
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count + 3'd1;
          end
        end
        default: begin
          count <= '0;
          state <= IDLE;
        end
      endcase
    end else if (timeout) begin
      count <= '0;
      shreg <= '0;
      state <= IDLE;
    end
  end

  // Output register and status pulses. A completion in the same cycle as an
  // accept replaces the outgoing block, so data_valid stays high.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= timeout;
      if (block_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= next_block;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsm_8to64.sv
// Scoreboard bench for fsm_8to64: stimulus pushes expected blocks into a
// queue, a negedge monitor pops and compares at every accepted transfer.
module tb_fsm_8to64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_done = 1'b0;
  logic [63:0] data_out;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        overrun;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int ovr_seen = 0;
  int ferr_seen = 0;
  logic [63:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [63:0] held = '0;

  fsm_8to64 #(.TIMEOUT_CYCLES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor: transfers, hold stability, pulse counting.
  always @(negedge clock) begin
    if (!reset) begin
      if (data_valid && hold_prev) check("hold_stable", data_out, held);
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block actual=%h required=none", data_out);
        end else begin
          check("block", data_out, exp_q.pop_front());
        end
      end
      if (overrun) ovr_seen++;
      if (frame_err) ferr_seen++;
      hold_prev = data_valid && !data_ready;
      held      = data_out;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1 rx_done = 1'b0;
    end
  endtask

  // Sends blk MSB byte first; gap idle cycles between bytes; optionally
  // raises data_ready together with the last byte.
  task automatic send_block(input logic [63:0] blk, input int gap, input bit ready_last);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      rx_data = blk[63 - 8*i -: 8];
      rx_done = 1'b1;
      if (ready_last && i == 7) data_ready = 1'b1;
      if (gap > 0 && i < 7) idle(gap);
    end
    @(posedge clock);
    #1 rx_done = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] blk, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      rx_data = blk[63 - 8*i -: 8];
      rx_done = 1'b1;
    end
    @(posedge clock);
    #1 rx_done = 1'b0;
  endtask

  initial begin
    int exp_ferr;
    int budget;
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data_out", data_out, 64'h0);
    check("rst_valid", {63'h0, data_valid}, 64'h0);
    check("rst_overrun", {63'h0, overrun}, 64'h0);
    check("rst_frame_err", {63'h0, frame_err}, 64'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    // 1. Basic packing with gaps, ready held high
    data_ready = 1'b1;
    exp_q.push_back(64'h0123456789ABCDEF);
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1;
      rx_data = 8'h01 + 8'(i * 8'h22);
      rx_done = 1'b1;
      if (i < 7) idle(2);
    end
    check("t1_not_early", {63'h0, data_valid}, 64'h0);
    @(posedge clock);
    #1 rx_done = 1'b0;
    check("t1_latency_valid", {63'h0, data_valid}, 64'h1);
    check("t1_data", data_out, 64'h0123456789ABCDEF);
    @(posedge clock);
    #1;
    check("t1_valid_one_cycle", {63'h0, data_valid}, 64'h0);
    idle(2);

    // 2. Back-pressure: A held, B dropped with overrun, C delivered
    data_ready = 1'b0;
    exp_q.push_back(64'hA0A1A2A3A4A5A6A7);
    send_block(64'hA0A1A2A3A4A5A6A7, 1, 1'b0);
    send_block(64'hB0B1B2B3B4B5B6B7, 0, 1'b0);
    idle(1);
    check("t2_overrun_count", 64'(ovr_seen), 64'd1);
    check("t2_data_held_A", data_out, 64'hA0A1A2A3A4A5A6A7);
    idle(2);
    data_ready = 1'b1;
    idle(2);
    exp_q.push_back(64'hC0C1C2C3C4C5C6C7);
    send_block(64'hC0C1C2C3C4C5C6C7, 0, 1'b0);
    idle(3);

    // 3. Same-cycle accept and reload
    data_ready = 1'b0;
    exp_q.push_back(64'hD0D1D2D3D4D5D6D7);
    send_block(64'hD0D1D2D3D4D5D6D7, 0, 1'b0);
    idle(2);
    exp_q.push_back(64'hE0E1E2E3E4E5E6E7);
    send_block(64'hE0E1E2E3E4E5E6E7, 0, 1'b1);
    check("t3_valid_continuous", {63'h0, data_valid}, 64'h1);
    check("t3_data_B", data_out, 64'hE0E1E2E3E4E5E6E7);
    idle(3);
    check("t3_no_overrun", 64'(ovr_seen), 64'd1);

    // 4. Mid-block reset
    send_bytes(64'h5051525354000000, 5);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    check("t4_reset_valid", {63'h0, data_valid}, 64'h0);
    exp_q.push_back(64'h0001020304050607);
    send_block(64'h0001020304050607, 1, 1'b0);
    idle(3);

`ifdef FSM_8TO64_TIMEOUT_EN
    // 5. Timeout discards partial block
    send_bytes(64'h1122330000000000, 3);
    idle(20);
    check("t5_frame_err", 64'(ferr_seen), 64'd1);
    exp_q.push_back(64'hFFFEFDFCFBFAF9F8);
    send_block(64'hFFFEFDFCFBFAF9F8, 0, 1'b0);
    idle(3);
    exp_ferr = 1;
`else
    exp_ferr = 0;
`endif

    // 6. Back-to-back strobes
    exp_q.push_back(64'h1011121314151617);
    send_block(64'h1011121314151617, 0, 1'b0);
    idle(3);

    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_overrun_count", 64'(ovr_seen), 64'd1);
    check("final_frame_err_count", 64'(ferr_seen), 64'(exp_ferr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
